// File: rtl/multdiv_issue_if.sv
// Pipeline-side and multdiv-side signals of the multdiv issue stage.
// The issue block is the slave; the pipeline/multdiv environment is the master.
interface multdiv_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_is_mult;
  logic        in_is_div;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        stall;
  logic        md_start_mult;
  logic        md_start_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_exception;

  modport master (
    output flush, in_valid, in_is_mult, in_is_div, in_a, in_b, in_rd,
    output md_result, md_exception, md_ready,
    input  stall, md_start_mult, md_start_div, md_a, md_b,
    input  out_valid, out_result, out_rd, out_exception
  );

  modport slave (
    input  flush, in_valid, in_is_mult, in_is_div, in_a, in_b, in_rd,
    input  md_result, md_exception, md_ready,
    output stall, md_start_mult, md_start_div, md_a, md_b,
    output out_valid, out_result, out_rd, out_exception
  );
endinterface

// File: rtl/multdiv_issue.sv
// Issues MULT/DIV to the iterative multdiv unit, stalls the pipeline until
// completion or watchdog timeout, then presents the result for one cycle.
module multdiv_issue #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CW      = 6
) (
  input logic           clock,
  input logic           reset,
  multdiv_issue_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] wd;
  logic          op_q;
  logic [4:0]    rd_q;
  logic          accept;
  logic          timeout;

  assign accept  = (state == IDLE) & bus.in_valid & (bus.in_is_mult | bus.in_is_div) & ~bus.flush;
  assign timeout = (wd == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (bus.md_ready || timeout) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // flush abandons everything except a completion already being presented
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wd                <= '0;
      op_q              <= 1'b0;
      rd_q              <= '0;
      bus.md_a          <= '0;
      bus.md_b          <= '0;
      bus.out_result    <= '0;
      bus.out_rd        <= '0;
      bus.out_exception <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bus.md_a <= bus.in_a;
        bus.md_b <= bus.in_b;
        rd_q     <= bus.in_rd;
        op_q     <= bus.in_is_mult;
      end
      if (state == ISSUE) wd <= '0;
      if (state == WAIT && !bus.flush) begin
        if (bus.md_ready) begin
          bus.out_result    <= bus.md_result;
          bus.out_exception <= bus.md_exception;
          bus.out_rd        <= rd_q;
        end else begin
          wd <= wd + 1'b1;
          if (timeout) begin
            bus.out_result    <= '0;
            bus.out_exception <= 1'b1;
            bus.out_rd        <= rd_q;
          end
        end
      end
    end
  end

  assign bus.stall         = ~reset & ~bus.flush & (accept | (state == ISSUE) | (state == WAIT));
  assign bus.md_start_mult = (state == ISSUE) &  op_q;
  assign bus.md_start_div  = (state == ISSUE) & ~op_q;
  assign bus.out_valid     = (state == DONE);

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: cycle-exact stall, start pulse and
// completion checks against hand-computed expectations.
module tb_multdiv_issue;
  localparam int TO = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;
  logic        last_exc = 1'b0;

  multdiv_issue_if bus();

  multdiv_issue #(.TIMEOUT(TO), .CW(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_is_mult   = 1'b0;
    bus.in_is_div    = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_rd        = '0;
    bus.md_result    = 32'h1234_5678;
    bus.md_exception = 1'b0;
    bus.md_ready     = 1'b0;
  endtask

  // Entered at posedge+1 of the accept cycle (n=0); leaves at posedge+1 of
  // the cycle after the last one checked.
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int rdy_at, input logic [31:0] res, input logic exc,
                        input logic stale, input int flush_at);
    int done;
    int last;
    logic [31:0] exp_res;
    logic        exp_exc;
    done = (flush_at >= 0) ? -1 : ((rdy_at >= 0) ? rdy_at + 1 : 2 + TO);
    last = (flush_at >= 0) ? rdy_at + 2 : done;
    for (int n = 0; n <= last; n++) begin
      bus.in_valid   = (flush_at >= 0) ? (n <= flush_at) : (n <= done);
      bus.in_is_mult = m;
      bus.in_is_div  = d;
      bus.in_a       = a;
      bus.in_b       = b;
      bus.in_rd      = rd;
      bus.flush      = (n == flush_at);
      if (n == rdy_at) begin
        bus.md_ready     = 1'b1;
        bus.md_result    = res;
        bus.md_exception = exc;
      end else if (stale && n <= 1) begin
        bus.md_ready     = 1'b1;
        bus.md_result    = 32'hDEAD_BEEF;
        bus.md_exception = 1'b1;
      end else begin
        bus.md_ready     = 1'b0;
        bus.md_result    = 32'h1234_5678;
        bus.md_exception = 1'b0;
      end
      #2;
      check({tag, ".stall"}, 32'(bus.stall),
            32'((flush_at >= 0) ? (n < flush_at) : (n < done)));
      check({tag, ".start_mult"}, 32'(bus.md_start_mult), 32'((n == 1) && m));
      check({tag, ".start_div"},  32'(bus.md_start_div),  32'((n == 1) && !m && d));
      check({tag, ".out_valid"},  32'(bus.out_valid),     32'(n == done));
      if (n == 1) begin
        check({tag, ".md_a"}, bus.md_a, a);
        check({tag, ".md_b"}, bus.md_b, b);
      end
      if (n == done) begin
        exp_res = (rdy_at >= 0) ? res : 32'h0;
        exp_exc = (rdy_at >= 0) ? exc : 1'b1;
        check({tag, ".out_result"},    bus.out_result,           exp_res);
        check({tag, ".out_rd"},        32'(bus.out_rd),          32'(rd));
        check({tag, ".out_exception"}, 32'(bus.out_exception),   32'(exp_exc));
        last_res = exp_res;
        last_rd  = rd;
        last_exc = exp_exc;
      end
      if (flush_at >= 0 && n == last) begin
        check({tag, ".kept_result"}, bus.out_result,         last_res);
        check({tag, ".kept_rd"},     32'(bus.out_rd),        32'(last_rd));
        check({tag, ".kept_exc"},    32'(bus.out_exception), 32'(last_exc));
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    bus.in_valid   = 1'b1;
    bus.in_is_mult = 1'b1;
    #2;
    check("rst.stall",     32'(bus.stall),         32'h0);
    check("rst.start",     32'(bus.md_start_mult), 32'h0);
    check("rst.out_valid", 32'(bus.out_valid),     32'h0);
    check("rst.out_result",bus.out_result,         32'h0);
    check("rst.md_a",      bus.md_a,               32'h0);
    drive_idle();
    tick();
    tick();
    reset = 1'b0;

    // accept at n=0, ready at 18, -21 = 0xFFFFFFEB
    run_op("mult", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 18, 32'hFFFF_FFEB, 1'b0, 1'b0, -1);
    run_op("div_stale", 1'b0, 1'b1, 32'd100, 32'd7, 5'd9, 34, 32'd14, 1'b0, 1'b1, -1);
    run_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, 5'd3, 6, 32'h0, 1'b1, 1'b0, -1);
    run_op("both_ops", 1'b1, 1'b1, 32'd3, 32'd4, 5'd7, 4, 32'd12, 1'b0, 1'b0, -1);
    run_op("timeout", 1'b1, 1'b0, 32'd9, 32'd9, 5'd11, -1, 32'h0, 1'b0, 1'b0, -1);
    run_op("flush", 1'b0, 1'b1, 32'd50, 32'd5, 5'd20, 8, 32'd10, 1'b0, 1'b0, 5);
    run_op("after_flush", 1'b1, 1'b0, 32'd6, 32'd7, 5'd1, 3, 32'd42, 1'b0, 1'b0, -1);

    // in_valid with no op bit is ignored
    bus.in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #2;
      check("noop.stall", 32'(bus.stall), 32'h0);
      check("noop.start", 32'({bus.md_start_mult, bus.md_start_div}), 32'h0);
      tick();
    end
    drive_idle();

    // reset asserted while in WAIT
    bus.in_valid   = 1'b1;
    bus.in_is_div  = 1'b1;
    bus.in_a       = 32'd77;
    bus.in_b       = 32'd3;
    bus.in_rd      = 5'd4;
    for (int n = 0; n < 5; n++) tick();
    reset = 1'b1;
    #2;
    check("wrst.stall",      32'(bus.stall),                                32'h0);
    check("wrst.start",      32'({bus.md_start_mult, bus.md_start_div}),    32'h0);
    check("wrst.out_valid",  32'(bus.out_valid),                            32'h0);
    check("wrst.out_result", bus.out_result,                                32'h0);
    check("wrst.out_rd",     32'(bus.out_rd),                               32'h0);
    check("wrst.out_exc",    32'(bus.out_exception),                        32'h0);
    check("wrst.md_ab",      bus.md_a | bus.md_b,                           32'h0);
    drive_idle();
    tick();
    reset = 1'b0;
    tick();
    run_op("post_rst", 1'b0, 1'b1, 32'd21, 32'd3, 5'd2, 5, 32'd7, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
